// File: rtl/iterative_muldiv_unit_pkg.sv
// Shared types and small decode helpers for the iterative multiply/divide unit.
package iterative_muldiv_unit_pkg;

  // Operation encoding presented by the ALU decode.
  typedef enum logic [1:0] {
    md_mulu = 2'b00,
    md_muls = 2'b01,
    md_divu = 2'b10,
    md_divs = 2'b11
  } lc3b_mdop;

  // Engine state, also exported for debug and checker binding.
  typedef enum logic [1:0] {
    md_idle = 2'b00,
    md_busy = 2'b01,
    md_done = 2'b10
  } lc3b_mdstate;

  // The upper opcode bit selects divide.
  function automatic logic op_is_div(input lc3b_mdop op);
    return op[1];
  endfunction

  // The lower opcode bit selects signed operands.
  function automatic logic op_is_signed(input lc3b_mdop op);
    return op[0];
  endfunction

endpackage

// File: rtl/iterative_muldiv_unit_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit.
//
// Handshake: this is a hold/release protocol, not valid/ready. EX asserts
// op_valid with stable operands for as long as the instruction sits in EX.
// The unit answers with a combinational stall while it accepts and iterates;
// when stall drops (state == md_done) result/div_by_zero are valid and stay
// valid until EX pulses flow (instruction leaves EX) or flush (squash).
// A cycle with op_valid && flush is never an accept.
interface iterative_muldiv_unit_if #(
  parameter int WIDTH = 16
);
  import iterative_muldiv_unit_pkg::*;

  logic              op_valid;
  lc3b_mdop          op;
  logic              hi_sel;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              flow;
  logic              flush;
  logic [WIDTH-1:0]  result;
  logic              stall;
  logic              div_by_zero;
  lc3b_mdstate       state;

  // Pipeline (EX stage) side.
  modport master (
    output op_valid, op, hi_sel, a, b, flow, flush,
    input  result, stall, div_by_zero, state
  );

  // Engine side.
  modport slave (
    input  op_valid, op, hi_sel, a, b, flow, flush,
    output result, stall, div_by_zero, state
  );

endinterface

// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle multiply/divide engine for the EX stage.
// Multiply is LSB-first shift-add, divide is restoring; both share one adder
// and the same high/low register pair. Signed ops run on magnitudes and the
// sign is fixed up once when the last step completes.
module iterative_muldiv_unit
  import iterative_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  iterative_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Two's-complement negate when neg is set (operand width).
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Two's-complement negate when neg is set (full product width).
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  // Architectural state.
  lc3b_mdstate        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic               hi_sel_q;
  logic               neg_q;     // product / quotient negative
  logic               rneg_q;    // dividend negative (remainder sign)
  logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_q;     // product high half or partial remainder
  logic [WIDTH-1:0]   lo_q;      // multiplier/product low half or dividend/quotient
  logic [WIDTH-1:0]   result_q;
  logic               dbz_q;

  // Accept-side decode.
  logic               in_signed;
  logic               in_div;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Shared adder and per-step next values.
  logic [WIDTH:0]     add_l;
  logic [WIDTH:0]     add_r;
  logic               add_c;
  logic [WIDTH+1:0]   add_sum;
  logic               no_borrow;
  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] fin_prod;
  logic [WIDTH-1:0]   fin_result;

  // Operand magnitudes. MIN's magnitude 2^(WIDTH-1) is representable as an
  // unsigned WIDTH-bit value, and the trial remainder below is WIDTH+1 bits,
  // so no step of the datapath can overflow.
  always_comb begin
    in_signed = op_is_signed(bus.op);
    in_div    = op_is_div(bus.op);
    a_neg     = in_signed & bus.a[WIDTH-1];
    b_neg     = in_signed & bus.b[WIDTH-1];
    b_zero    = (bus.b == '0);
    a_mag     = neg_w(bus.a, a_neg);
    b_mag     = neg_w(bus.b, b_neg);
  end

  // One radix-2 step through the shared adder: add for multiply, subtract for divide.
  always_comb begin
    add_l     = '0;
    add_r     = '0;
    add_c     = 1'b0;
    step_acc  = acc_q;
    step_lo   = lo_q;
    no_borrow = 1'b0;
    if (is_div_q) begin
      add_l = {acc_q, lo_q[WIDTH-1]};
      add_r = ~{1'b0, opnd_q};
      add_c = 1'b1;
    end else begin
      add_l = {1'b0, acc_q};
      add_r = lo_q[0] ? {1'b0, opnd_q} : '0;
      add_c = 1'b0;
    end
    add_sum = {1'b0, add_l} + {1'b0, add_r} + {{(WIDTH+1){1'b0}}, add_c};
    if (is_div_q) begin
      no_borrow = add_sum[WIDTH+1];
      step_acc  = no_borrow ? add_sum[WIDTH-1:0] : add_l[WIDTH-1:0];
      step_lo   = {lo_q[WIDTH-2:0], no_borrow};
    end else begin
      step_acc  = add_sum[WIDTH:1];
      step_lo   = {add_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction and half select applied to the values of the final step.
  always_comb begin
    fin_prod   = neg_2w({step_acc, step_lo}, neg_q);
    fin_result = '0;
    if (is_div_q) begin
      fin_result = hi_sel_q ? neg_w(step_acc, rneg_q) : neg_w(step_lo, neg_q);
    end else begin
      fin_result = hi_sel_q ? fin_prod[2*WIDTH-1:WIDTH] : fin_prod[WIDTH-1:0];
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= md_idle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      hi_sel_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        md_idle: begin
          if (bus.op_valid && !bus.flush) begin
            is_div_q <= in_div;
            hi_sel_q <= bus.hi_sel;
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            acc_q    <= '0;
            if (in_div) begin
              opnd_q <= b_mag;
              lo_q   <= a_mag;
            end else begin
              opnd_q <= a_mag;
              lo_q   <= b_mag;
            end
            if (in_div && b_zero) begin
              // Divide by zero skips iteration: all-ones quotient, raw dividend as remainder.
              state_q  <= md_done;
              cnt_q    <= '0;
              result_q <= bus.hi_sel ? bus.a : '1;
              dbz_q    <= 1'b1;
            end else begin
              state_q  <= md_busy;
              cnt_q    <= CNT_W'(WIDTH);
            end
          end
        end
        md_busy: begin
          if (bus.flush) begin
            state_q <= md_idle;
            cnt_q   <= '0;
          end else begin
            acc_q <= step_acc;
            lo_q  <= step_lo;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q  <= md_done;
              result_q <= fin_result;
              dbz_q    <= 1'b0;
            end
          end
        end
        md_done: begin
          // Hold the answer until EX advances or is squashed; never re-accept here.
          if (bus.flow || bus.flush) begin
            state_q  <= md_idle;
            result_q <= '0;
            dbz_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= md_idle;
        end
      endcase
    end
  end

  assign bus.stall       = ((state_q == md_idle) && bus.op_valid && !bus.flush) ||
                           (state_q == md_busy);
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Directed bench for iterative_muldiv_unit (WIDTH=16 plus a WIDTH=8 instance).
module tb_iterative_muldiv_unit;
  import iterative_muldiv_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  iterative_muldiv_unit_if #(.WIDTH(16)) bus16 ();
  iterative_muldiv_unit_if #(.WIDTH(8))  bus8 ();

  iterative_muldiv_unit #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  iterative_muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain integer arithmetic: full product, truncating division.
  function automatic logic [31:0] ref_res(input int w, input lc3b_mdop op, input logic hi,
                                          input logic [31:0] a, input logic [31:0] b,
                                          output logic dbz);
    longint mask, ua, ub, sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
    sb = ub[w-1] ? ub - (longint'(1) << w) : ub;
    dbz = 1'b0;
    p = 0; q = 0; r = 0;
    case (op)
      md_mulu: p = ua * ub;
      md_muls: p = sa * sb;
      md_divu: if (ub == 0) begin q = mask; r = ua; dbz = 1'b1; end
               else begin q = ua / ub; r = ua % ub; end
      default: if (ub == 0) begin q = mask; r = ua; dbz = 1'b1; end
               else begin q = sa / sb; r = sa % sb; end
    endcase
    if (op == md_mulu || op == md_muls)
      return hi ? 32'((p >> w) & mask) : 32'(p & mask);
    else
      return hi ? 32'(r & mask) : 32'(q & mask);
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [15:0] exp_q[$];
  logic        chk_en  = 1'b0;
  logic [15:0] exp_res = '0;
  logic        exp_dbz = 1'b0;
  string       exp_tag = "";

  // Every cycle the unit sits in DONE: answer held, no stall, no restart.
  always @(negedge clk) begin
    if (chk_en) begin
      check({exp_tag, " done.result"}, 32'(bus16.result), 32'(exp_res));
      check({exp_tag, " done.dbz"},    32'(bus16.div_by_zero), 32'(exp_dbz));
      check({exp_tag, " done.stall"},  32'(bus16.stall), 32'd0);
      check({exp_tag, " done.state"},  32'(bus16.state), 32'(md_done));
    end
  end

  task automatic check_idle16(input string tag);
    check({tag, " idle.state"},  32'(bus16.state), 32'(md_idle));
    check({tag, " idle.stall"},  32'(bus16.stall), 32'd0);
    check({tag, " idle.result"}, 32'(bus16.result), 32'd0);
    check({tag, " idle.dbz"},    32'(bus16.div_by_zero), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_op(input string tag, input lc3b_mdop op, input logic hi,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] lit, input logic lit_dbz,
                        input int hold, input logic exit_flush);
    logic [31:0] m;
    logic        mdbz;
    int          n;
    int          exp_stall;
    m = ref_res(16, op, hi, 32'(a), 32'(b), mdbz);
    exp_q.push_back(m[15:0]);
    exp_stall = (op_is_div(op) && b == 16'h0) ? 1 : 17;
    @(posedge clk); #1;
    bus16.op_valid = 1'b1;
    bus16.op       = op;
    bus16.hi_sel   = hi;
    bus16.a        = a;
    bus16.b        = b;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus16.stall) break;
      n++;
      if (n == 2) begin
        // Operands are latched at accept; churn them while iterating.
        bus16.a      = 16'($urandom_range(0, 65535));
        bus16.b      = 16'($urandom_range(0, 65535));
        bus16.op     = lc3b_mdop'(2'($urandom_range(0, 3)));
        bus16.hi_sel = 1'($urandom_range(0, 1));
      end
    end
    check({tag, " stall_cycles"}, 32'(n), 32'(exp_stall));
    check({tag, " literal"},      32'(bus16.result), 32'(lit));
    check({tag, " literal.dbz"},  32'(bus16.div_by_zero), 32'(lit_dbz));
    check({tag, " model"},        32'(bus16.result), 32'(exp_q.pop_front()));
    exp_res = m[15:0];
    exp_dbz = mdbz;
    exp_tag = tag;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (exit_flush) bus16.flush = 1'b1;
    else            bus16.flow  = 1'b1;
    @(posedge clk); #1;
    chk_en         = 1'b0;
    bus16.flow     = 1'b0;
    bus16.flush    = 1'b0;
    bus16.op_valid = 1'b0;
    @(negedge clk);
    check_idle16(tag);
  endtask

  // Start a long multiply, then kill it with flush or reset a few steps in.
  task automatic abort_busy(input string tag, input logic use_reset);
    @(posedge clk); #1;
    bus16.op_valid = 1'b1;
    bus16.op       = md_mulu;
    bus16.hi_sel   = 1'b0;
    bus16.a        = 16'h1234;
    bus16.b        = 16'h5678;
    @(posedge clk); #1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, " busy.stall"}, 32'(bus16.stall), 32'd1);
    @(posedge clk); #1;
    if (use_reset) reset = 1'b1;
    else           bus16.flush = 1'b1;
    bus16.op_valid = 1'b0;
    @(posedge clk); #1;
    reset       = 1'b0;
    bus16.flush = 1'b0;
    @(negedge clk);
    check_idle16(tag);
  endtask

  task automatic run_op8(input string tag, input logic hi, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] lit);
    logic [31:0] m;
    logic        mdbz;
    int          n;
    m = ref_res(8, md_mulu, hi, 32'(a), 32'(b), mdbz);
    @(posedge clk); #1;
    bus8.op_valid = 1'b1;
    bus8.op       = md_mulu;
    bus8.hi_sel   = hi;
    bus8.a        = a;
    bus8.b        = b;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus8.stall) break;
      n++;
    end
    check({tag, " stall_cycles"}, 32'(n), 32'd9);
    check({tag, " literal"},      32'(bus8.result), 32'(lit));
    check({tag, " model"},        32'(bus8.result), 32'(m[7:0]));
    check({tag, " dbz"},          32'(bus8.div_by_zero), 32'(mdbz));
    @(posedge clk); #1;
    bus8.flow = 1'b1;
    @(posedge clk); #1;
    bus8.flow     = 1'b0;
    bus8.op_valid = 1'b0;
    @(negedge clk);
    check({tag, " idle.state"}, 32'(bus8.state), 32'(md_idle));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus16.op_valid = 1'b0; bus16.op = md_mulu; bus16.hi_sel = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.flow = 1'b0; bus16.flush = 1'b0;
    bus8.op_valid = 1'b0; bus8.op = md_mulu; bus8.hi_sel = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.flow = 1'b0; bus8.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle16("reset");
    check("reset w8.state", 32'(bus8.state), 32'(md_idle));
    check("reset w8.stall", 32'(bus8.stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Multiply
    run_op("mulu_lo",   md_mulu, 1'b0, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 0, 1'b0);
    run_op("mulu_hi",   md_mulu, 1'b1, 16'h00FF, 16'h0101, 16'h0000, 1'b0, 0, 1'b0);
    run_op("muls_lo",   md_muls, 1'b0, 16'hFFFE, 16'h0003, 16'hFFFA, 1'b0, 0, 1'b0);
    run_op("muls_hi",   md_muls, 1'b1, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 0, 1'b0);
    run_op("muls_min_hi", md_muls, 1'b1, 16'h8000, 16'h8000, 16'h4000, 1'b0, 0, 1'b0);
    run_op("muls_min_lo", md_muls, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b0, 0, 1'b0);
    run_op("muls_mix_hi", md_muls, 1'b1, 16'h7FFF, 16'h8000, 16'hC000, 1'b0, 0, 1'b0);
    run_op("muls_mix_lo", md_muls, 1'b0, 16'h7FFF, 16'h8000, 16'h8000, 1'b0, 0, 1'b0);

    // Divide
    run_op("divs_q",    md_divs, 1'b0, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 0, 1'b0);
    run_op("divs_r",    md_divs, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 0, 1'b0);
    run_op("divu_q",    md_divu, 1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 1'b0, 0, 1'b0);
    run_op("divu_r",    md_divu, 1'b1, 16'hFFF9, 16'h0002, 16'h0001, 1'b0, 0, 1'b0);
    run_op("divs_negb_q", md_divs, 1'b0, 16'h0064, 16'hFFF9, 16'hFFF2, 1'b0, 0, 1'b0);
    run_op("divs_negb_r", md_divs, 1'b1, 16'h0064, 16'hFFF9, 16'h0002, 1'b0, 0, 1'b0);

    // Divide-by-zero and MIN/-1
    run_op("divu_z_q",  md_divu, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 0, 1'b0);
    run_op("divu_z_r",  md_divu, 1'b1, 16'h1234, 16'h0000, 16'h1234, 1'b1, 0, 1'b0);
    run_op("divs_z_r",  md_divs, 1'b1, 16'hFFF9, 16'h0000, 16'hFFF9, 1'b1, 0, 1'b0);
    run_op("divs_min_q", md_divs, 1'b0, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 0, 1'b0);
    run_op("divs_min_r", md_divs, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 0, 1'b0);

    // Hold in DONE for 3 cycles, then back-to-back; flush out of DONE
    run_op("hold3",     md_mulu, 1'b0, 16'h0007, 16'h0009, 16'h003F, 1'b0, 3, 1'b0);
    run_op("b2b",       md_divu, 1'b0, 16'h0064, 16'h0007, 16'h000E, 1'b0, 0, 1'b0);
    run_op("done_flush", md_muls, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1, 1'b1);

    // flush together with op_valid in IDLE is not an accept
    @(posedge clk); #1;
    bus16.op_valid = 1'b1; bus16.flush = 1'b1;
    bus16.op = md_mulu; bus16.a = 16'h0005; bus16.b = 16'h0005;
    @(negedge clk);
    check("flush_accept stall", 32'(bus16.stall), 32'd0);
    @(posedge clk); #1;
    bus16.op_valid = 1'b0; bus16.flush = 1'b0;
    @(negedge clk);
    check_idle16("flush_accept");

    // Abort in BUSY by flush and by reset; a fresh op then works
    abort_busy("busy_flush", 1'b0);
    run_op("after_flush", md_mulu, 1'b0, 16'h0003, 16'h0004, 16'h000C, 1'b0, 0, 1'b0);
    abort_busy("busy_reset", 1'b1);
    run_op("after_reset", md_mulu, 1'b0, 16'h0003, 16'h0004, 16'h000C, 1'b0, 0, 1'b0);

    // WIDTH=8 instance
    run_op8("w8_lo", 1'b0, 8'h0F, 8'h11, 8'hFF);
    run_op8("w8_hi", 1'b1, 8'h0F, 8'h11, 8'h00);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so a stuck DUT still produces a summary.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
